shreg_universal: RTL and testbench

Parametrised universal shift register, the successor of the fixed 8-bit serial-in register. It supports hold, parallel load, clear, logical and arithmetic shifts and rotates. A small controller runs a requested number of single-bit steps, one per clock, and signals completion with a busy/done handshake. It sits between the serial pin logic and the datapath and acts as both a serialiser and a deserialiser.

---
 rtl/shreg_pkg.sv | 26 ++
 rtl/shreg_step.sv | 30 +++
 rtl/shreg_universal.sv | 109 ++++++++++
 tb/tb_shreg_universal.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation codes and controller states.
package shreg_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SHL  = 3'd1,
        SHR  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        ASR  = 3'd5,
        LOAD = 3'd6,
        CLR  = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift/rotate modes run for a programmable number of steps; the rest complete in one edge.
    function automatic logic is_step_mode(input mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// One-step next-state function of the shift register, shared by the accepting edge and RUN edges.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_sin,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_q_next
);

    // Select the register contents after a single operation step.
    always_comb begin
        o_q_next = i_q;
        case (i_mode)
            HOLD:    o_q_next = i_q;
            SHL:     o_q_next = {i_q[WIDTH-2:0], i_sin};
            SHR:     o_q_next = {i_sin, i_q[WIDTH-1:1]};
            ROL:     o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            ROR:     o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            ASR:     o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            LOAD:    o_q_next = i_pin;
            CLR:     o_q_next = '0;
            default: o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/shreg_universal.sv
// Universal shift register with a step-count controller and busy/done handshake.
module shreg_universal
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_next;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   w_rem_next;
    mode_t              r_mode;
    mode_t              w_mode_next;
    mode_t              w_mode_in;
    mode_t              w_step_mode;
    logic [WIDTH-1:0]   w_step_q;

    assign w_mode_in   = mode_t'(mode);
    // In IDLE the requested mode drives the step; in RUN the latched one does.
    assign w_step_mode = (r_state == IDLE) ? w_mode_in : r_mode;

    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q      (r_q),
        .i_sin    (sin),
        .i_mode   (w_step_mode),
        .i_pin    (pin),
        .o_q_next (w_step_q)
    );

    // State, register contents, remaining-step counter and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_mode  <= HOLD;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_rem   <= w_rem_next;
            r_mode  <= w_mode_next;
        end
    end

    // Controller: accept in IDLE, step in RUN, one-cycle DONE before returning to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_rem_next   = r_rem;
        w_mode_next  = r_mode;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DONE;
                    if (is_step_mode(w_mode_in)) begin
                        if (count != '0) begin
                            w_q_next    = w_step_q;
                            w_mode_next = w_mode_in;
                            w_rem_next  = count - CNT_W'(1);
                            if (count != CNT_W'(1)) begin
                                w_state_next = RUN;
                            end
                        end
                    end else begin
                        w_q_next = w_step_q;
                    end
                end
            end
            RUN: begin
                w_q_next   = w_step_q;
                w_rem_next = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_shreg_universal.sv
// Directed testbench for shreg_universal (WIDTH=8).
module tb_shreg_universal;
    import shreg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] pin;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    int n_tests;
    int n_fail;

    shreg_universal #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .count    (count),
        .pin      (pin),
        .sin      (sin),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before inputs change or outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = LOAD; pin = 8'hFF; count = 4'd3; sin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", i, q, busy, done);
            end
        end
        rst = 1'b0; start = 1'b0;
        tick();
        n_tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout_msb !== 1'b0 || sout_lsb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got q=%h busy=%b done=%b msb=%b lsb=%b, expected all zero", q, busy, done, sout_msb, sout_lsb);
        end
    endtask

    task automatic test_load_rol();
        start = 1'b1; mode = LOAD; pin = 8'h81;
        tick();
        start = 1'b0;
        n_tests++;
        if (q !== 8'h81 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load: got q=%h done=%b busy=%b, expected q=81 done=1 busy=0", q, done, busy);
        end
        n_tests++;
        if (sout_msb !== 1'b1 || sout_lsb !== 1'b1) begin
            n_fail++;
            $display("FAIL load_taps: got msb=%b lsb=%b, expected 1 1", sout_msb, sout_lsb);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_pulse: got done=%b, expected 0", done);
        end
        start = 1'b1; mode = ROL; count = 4'd1; pin = 8'h55;
        tick();
        start = 1'b0;
        n_tests++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rol1: got q=%h done=%b busy=%b, expected q=03 done=1 busy=0", q, done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || q !== 8'h03) begin
            n_fail++;
            $display("FAIL rol1_after: got q=%h done=%b, expected q=03 done=0", q, done);
        end
    endtask

    task automatic test_shr_fill();
        logic [7:0] exp_q [3];
        logic       exp_busy [3];
        logic       exp_done [3];
        exp_q = '{8'h80, 8'hC0, 8'hE0};
        exp_busy = '{1'b1, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b1};
        start = 1'b1; mode = CLR;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = SHR; count = 4'd3; sin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            n_tests++;
            if (q !== exp_q[i] || busy !== exp_busy[i] || done !== exp_done[i]) begin
                n_fail++;
                $display("FAIL shr_fill[%0d]: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         i, q, busy, done, exp_q[i], exp_busy[i], exp_done[i]);
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shr_fill_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_asr_shl();
        start = 1'b1; mode = LOAD; pin = 8'h80;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = ASR; count = 4'd2; sin = 1'b0;
        tick();
        start = 1'b0;
        n_tests++;
        if (q !== 8'hC0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL asr_step1: got q=%h busy=%b, expected q=c0 busy=1", q, busy);
        end
        tick();
        n_tests++;
        if (q !== 8'hE0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL asr_final: got q=%h done=%b, expected q=e0 done=1", q, done);
        end
        tick();
        start = 1'b1; mode = SHL; count = 4'd8;
        for (int i = 0; i < 8; i++) begin
            sin = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            start = 1'b0;
        end
        n_tests++;
        if (q !== 8'hAA || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shl8: got q=%h done=%b busy=%b, expected q=aa done=1 busy=0", q, done, busy);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int         n_done;
        logic [7:0] q_at_done;
        n_done = 0;
        q_at_done = 8'hXX;
        start = 1'b1; mode = LOAD; pin = 8'h01;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = SHL; count = 4'd5; sin = 1'b0;
        tick();
        start = 1'b1; mode = CLR; count = 4'd1; pin = 8'hFF;
        tick();
        start = 1'b0; mode = HOLD;
        n_tests++;
        if (q !== 8'h04 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_step2: got q=%h busy=%b, expected q=04 busy=1", q, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                q_at_done = q;
            end
        end
        n_tests++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL busy_done_count: got %0d pulses, expected 1", n_done);
        end
        n_tests++;
        if (q_at_done !== 8'h20 || q !== 8'h20) begin
            n_fail++;
            $display("FAIL busy_final_q: got q_at_done=%h q=%h, expected 20", q_at_done, q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [6];
        logic       exp_busy [6];
        logic       exp_done [6];
        exp_q    = '{8'h03, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h18};
        exp_busy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        start = 1'b1; mode = LOAD; pin = 8'h81;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = ROL; count = 4'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) start = 1'b0;
            n_tests++;
            if (q !== exp_q[i] || busy !== exp_busy[i] || done !== exp_done[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         i, q, busy, done, exp_q[i], exp_busy[i], exp_done[i]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_count0_reset();
        int n_done;
        n_done = 0;
        start = 1'b1; mode = LOAD; pin = 8'h20;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = SHL; count = 4'd0; sin = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (q !== 8'h20 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL count0: got q=%h done=%b busy=%b, expected q=20 done=1 busy=0", q, done, busy);
        end
        tick();
        start = 1'b1; mode = ROR; count = 4'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
        end
        n_tests++;
        if (q !== 8'h04 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ror_mid: got q=%h busy=%b, expected q=04 busy=1", q, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ror_reset: got q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done !== 0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL ror_after_reset: got %0d active cycles q=%h, expected 0 and q=00", n_done, q);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; mode = HOLD; count = '0; pin = '0; sin = 1'b0;
        test_reset();
        test_load_rol();
        test_shr_fill();
        test_asr_shl();
        test_ignore_busy();
        test_back_to_back();
        test_count0_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
